// File: rtl/rca_config_sequencer_pkg.sv
// Shared RCA configuration typedefs: target type codes, queue entry layout and
// sequencer FSM states.
package rca_config_sequencer_pkg;

  localparam int RCA_NUM_RCAS   = 4;
  localparam int RCA_CFG_ADDR_W = 8;
  localparam int RCA_XLEN       = 32;
  localparam int RCA_IDX_W      = $clog2(RCA_NUM_RCAS);

  typedef enum logic [2:0] {
    CFG_CPU_SRC_REG  = 3'd0,
    CFG_CPU_DEST_REG = 3'd1,
    CFG_GRID_MUX     = 3'd2,
    CFG_IO_MUX       = 3'd3,
    CFG_RESULT_MUX   = 3'd4,
    CFG_IO_INP_MAP   = 3'd5,
    CFG_INPUT_CONST  = 3'd6,
    CFG_RESERVED     = 3'd7
  } rca_cfg_type_t;

  typedef struct packed {
    rca_cfg_type_t               typ;
    logic [RCA_IDX_W-1:0]        rca;
    logic [RCA_CFG_ADDR_W-1:0]   addr;
    logic [RCA_XLEN-1:0]         data;
  } rca_cfg_entry_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CHECK,
    SEQ_WAIT_QUIESCE,
    SEQ_WRITE
  } seq_state_t;

  // CPU register-address updates do not touch the datapath, so they may land
  // while the RCA still has use instructions in flight.
  function automatic logic needs_quiesce(input rca_cfg_type_t t);
    return !(t inside {CFG_CPU_SRC_REG, CFG_CPU_DEST_REG});
  endfunction

endpackage

// File: rtl/rca_cfg_fifo.sv
// In-order config instruction queue; head entry is read straight from the
// storage registers so the payload stays stable while it waits to retire.
module rca_cfg_fifo
  import rca_config_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  rca_cfg_entry_t         push_entry,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output rca_cfg_entry_t         head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  rca_cfg_entry_t mem [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage carries no reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/rca_config_sequencer.sv
// Buffers RCA config writes, waits for the targeted RCA to go quiescent, and
// blocks use instructions for any RCA that still has config outstanding.
module rca_config_sequencer
  import rca_config_sequencer_pkg::*;
#(
  parameter int NUM_RCAS   = RCA_NUM_RCAS,
  parameter int FIFO_DEPTH = 4,
  parameter int CFG_ADDR_W = RCA_CFG_ADDR_W,
  parameter int XLEN       = RCA_XLEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [2:0]                  issue_type,
  input  logic [$clog2(NUM_RCAS)-1:0] issue_rca,
  input  logic [CFG_ADDR_W-1:0]       issue_addr,
  input  logic [XLEN-1:0]             issue_data,
  input  logic [NUM_RCAS-1:0]         rca_busy,
  output logic                        cfg_valid,
  input  logic                        cfg_ready,
  output logic [2:0]                  cfg_type,
  output logic [$clog2(NUM_RCAS)-1:0] cfg_rca,
  output logic [CFG_ADDR_W-1:0]       cfg_addr,
  output logic [XLEN-1:0]             cfg_data,
  output logic [NUM_RCAS-1:0]         use_blocked,
  output logic                        idle
);

  localparam int IDX_W  = $clog2(NUM_RCAS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PEND_W = $clog2(FIFO_DEPTH + 1);

  seq_state_t     state;
  rca_cfg_entry_t push_entry;
  rca_cfg_entry_t head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic           push;
  logic           pop;
  logic           more_after_pop;
  logic           head_busy;
  logic [PEND_W-1:0] pending [NUM_RCAS];

  assign issue_ready = !fifo_full;
  assign push        = issue_valid && !fifo_full;
  assign push_entry  = '{typ:  rca_cfg_type_t'(issue_type),
                         rca:  issue_rca,
                         addr: issue_addr,
                         data: issue_data};

  rca_cfg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (head)
  );

  assign pop = ((state == SEQ_CHECK) && (head.typ == CFG_RESERVED)) ||
               ((state == SEQ_WRITE) && cfg_ready);

  // A same-cycle accept keeps the queue non-empty even if the head retires.
  assign more_after_pop = (fifo_count > CNT_W'(1)) || push;
  assign head_busy      = rca_busy[head.rca];

  assign cfg_type = head.typ;
  assign cfg_rca  = head.rca;
  assign cfg_addr = head.addr;
  assign cfg_data = head.data;
  assign idle     = fifo_empty && (state == SEQ_IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      cfg_valid <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (push || !fifo_empty) state <= SEQ_CHECK;
        end
        SEQ_CHECK: begin
          if (head.typ == CFG_RESERVED) begin
            state <= more_after_pop ? SEQ_CHECK : SEQ_IDLE;
          end else if (needs_quiesce(head.typ) && head_busy) begin
            state <= SEQ_WAIT_QUIESCE;
          end else begin
            state     <= SEQ_WRITE;
            cfg_valid <= 1'b1;
          end
        end
        SEQ_WAIT_QUIESCE: begin
          if (!head_busy) begin
            state     <= SEQ_WRITE;
            cfg_valid <= 1'b1;
          end
        end
        SEQ_WRITE: begin
          if (cfg_ready) begin
            cfg_valid <= 1'b0;
            state     <= more_after_pop ? SEQ_CHECK : SEQ_IDLE;
          end
        end
        default: begin
          state     <= SEQ_IDLE;
          cfg_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_RCAS; r++) pending[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        if ((push && issue_rca == IDX_W'(r)) && !(pop && head.rca == IDX_W'(r)))
          pending[r] <= pending[r] + PEND_W'(1);
        else if (!(push && issue_rca == IDX_W'(r)) && (pop && head.rca == IDX_W'(r)))
          pending[r] <= pending[r] - PEND_W'(1);
      end
    end
  end

  // NOTE: every output of this block is assigned up front, so no latch forms.
  always_comb begin
    use_blocked = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      use_blocked[r] = (pending[r] != '0) || (push && issue_rca == IDX_W'(r));
    end
  end

endmodule

// File: tb/tb_rca_config_sequencer.sv
// Directed bench for rca_config_sequencer: one task per scenario, inline checks.
module tb_rca_config_sequencer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_type;
  logic [1:0]  issue_rca;
  logic [7:0]  issue_addr;
  logic [31:0] issue_data;
  logic [3:0]  rca_busy;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_type;
  logic [1:0]  cfg_rca;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [3:0]  use_blocked;
  logic        idle;

  int checks = 0;
  int errors = 0;

  rca_config_sequencer #(
    .NUM_RCAS   (4),
    .FIFO_DEPTH (4),
    .CFG_ADDR_W (8),
    .XLEN       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_type  (issue_type),
    .issue_rca   (issue_rca),
    .issue_addr  (issue_addr),
    .issue_data  (issue_data),
    .rca_busy    (rca_busy),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_type    (cfg_type),
    .cfg_rca     (cfg_rca),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .use_blocked (use_blocked),
    .idle        (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic [2:0] t, input logic [1:0] r,
                             input logic [7:0] a, input logic [31:0] d);
    issue_valid = v;
    issue_type  = t;
    issue_rca   = r;
    issue_addr  = a;
    issue_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_issue(1'b0, 3'd0, 2'd0, 8'h00, 32'h0);
    rca_busy  = 4'b0000;
    cfg_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid: got %b want 0", cfg_valid); end
    checks++; if (use_blocked !== 4'b0000) begin errors++; $display("FAIL reset_use_blocked: got %b want 0000", use_blocked); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_write();
    rca_busy  = 4'b0000;
    cfg_ready = 1'b1;
    drive_issue(1'b1, 3'd2, 2'd2, 8'h05, 32'h3);
    @(negedge clk); // cycle N
    checks++; if (use_blocked !== 4'b0100) begin errors++; $display("FAIL single_ub_n: got %b want 0100", use_blocked); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n: got %b want 0", cfg_valid); end
    next_cycle();
    drive_issue(1'b0, 3'd0, 2'd0, 8'h00, 32'h0);
    @(negedge clk); // N+1
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n1: got %b want 0", cfg_valid); end
    checks++; if (use_blocked !== 4'b0100) begin errors++; $display("FAIL single_ub_n1: got %b want 0100", use_blocked); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_n1: got %b want 0", idle); end
    next_cycle();
    @(negedge clk); // N+2
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL single_valid_n2: got %b want 1", cfg_valid); end
    checks++; if ({cfg_type, cfg_rca, cfg_addr, cfg_data} !== {3'd2, 2'd2, 8'h05, 32'h3})
      begin errors++; $display("FAIL single_payload: got t=%0d r=%0d a=%h d=%h want t=2 r=2 a=05 d=3", cfg_type, cfg_rca, cfg_addr, cfg_data); end
    checks++; if (use_blocked !== 4'b0100) begin errors++; $display("FAIL single_ub_n2: got %b want 0100", use_blocked); end
    next_cycle();
    @(negedge clk); // N+3
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n3: got %b want 0", cfg_valid); end
    checks++; if (use_blocked !== 4'b0000) begin errors++; $display("FAIL single_ub_n3: got %b want 0000", use_blocked); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_n3: got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_wait_quiesce();
    rca_busy  = 4'b0010;
    cfg_ready = 1'b1;
    drive_issue(1'b1, 3'd3, 2'd1, 8'h11, 32'hAB);
    next_cycle();
    drive_issue(1'b0, 3'd0, 2'd0, 8'h00, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL quiesce_hold_%0d: got %b want 0", i, cfg_valid); end
      checks++; if (use_blocked[1] !== 1'b1) begin errors++; $display("FAIL quiesce_ub_%0d: got %b want 1", i, use_blocked[1]); end
      next_cycle();
    end
    rca_busy = 4'b0000;
    @(negedge clk);
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL quiesce_drop_cycle: got %b want 0", cfg_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL quiesce_write: got %b want 1", cfg_valid); end
    checks++; if ({cfg_type, cfg_rca, cfg_data} !== {3'd3, 2'd1, 32'hAB})
      begin errors++; $display("FAIL quiesce_payload: got t=%0d r=%0d d=%h want t=3 r=1 d=ab", cfg_type, cfg_rca, cfg_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL quiesce_idle: got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_dest_reg_no_wait();
    rca_busy  = 4'b0010;
    cfg_ready = 1'b1;
    drive_issue(1'b1, 3'd1, 2'd1, 8'h07, 32'h1F);
    next_cycle();
    drive_issue(1'b0, 3'd0, 2'd0, 8'h00, 32'h0);
    next_cycle();
    @(negedge clk); // N+2 despite busy
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL destreg_valid: got %b want 1", cfg_valid); end
    checks++; if ({cfg_type, cfg_addr, cfg_data} !== {3'd1, 8'h07, 32'h1F})
      begin errors++; $display("FAIL destreg_payload: got t=%0d a=%h d=%h want t=1 a=07 d=1f", cfg_type, cfg_addr, cfg_data); end
    next_cycle();
    rca_busy = 4'b0000;
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL destreg_idle: got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_full_and_order();
    logic        exp_v  [10];
    logic [31:0] exp_d  [10];
    logic [3:0]  exp_ub [10];
    exp_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_d  = '{32'h100, 32'h0, 32'h101, 32'h0, 32'h102, 32'h0, 32'h103, 32'h0, 32'h555, 32'h0};
    exp_ub = '{4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0000};
    rca_busy  = 4'b0000;
    cfg_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(1'b1, 3'd4, 2'(i), 8'(8'h20 + i), 32'(32'h100 + i));
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_ready_push%0d: got %b want 1", i, issue_ready); end
      next_cycle();
    end
    drive_issue(1'b1, 3'd6, 2'd0, 8'h30, 32'h555);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready_held%0d: got %b want 0", i, issue_ready); end
      checks++; if (use_blocked !== 4'b1111) begin errors++; $display("FAIL full_ub_held%0d: got %b want 1111", i, use_blocked); end
      checks++; if (cfg_valid !== 1'b1 || cfg_data !== 32'h100)
        begin errors++; $display("FAIL full_stable%0d: got v=%b d=%h want v=1 d=100", i, cfg_valid, cfg_data); end
      next_cycle();
    end
    cfg_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) drive_issue(1'b0, 3'd0, 2'd0, 8'h00, 32'h0);
      @(negedge clk);
      if (i == 0) begin
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_retire_ready: got %b want 0", issue_ready); end
      end
      if (i == 1) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_after_retire_ready: got %b want 1", issue_ready); end
      end
      checks++; if (cfg_valid !== exp_v[i]) begin errors++; $display("FAIL order_valid_%0d: got %b want %b", i, cfg_valid, exp_v[i]); end
      if (exp_v[i]) begin
        checks++; if (cfg_data !== exp_d[i]) begin errors++; $display("FAIL order_data_%0d: got %h want %h", i, cfg_data, exp_d[i]); end
      end
      checks++; if (use_blocked !== exp_ub[i]) begin errors++; $display("FAIL order_ub_%0d: got %b want %b", i, use_blocked, exp_ub[i]); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL order_idle: got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_reserved_skip();
    logic [2:0]  t_tab [3];
    logic [31:0] d_tab [3];
    logic [31:0] seen [$];
    int          saw_reserved;
    t_tab = '{3'd6, 3'd7, 3'd6};
    d_tab = '{32'hA, 32'hDEAD, 32'hB};
    saw_reserved = 0;
    rca_busy  = 4'b0000;
    cfg_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) drive_issue(1'b1, t_tab[i], 2'd3, 8'h40, d_tab[i]);
      else       drive_issue(1'b0, 3'd0, 2'd0, 8'h00, 32'h0);
      @(negedge clk);
      if (cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
        seen.push_back(cfg_data);
        if (cfg_type === 3'd7) saw_reserved++;
      end
      next_cycle();
    end
    checks++; if (seen.size() !== 2) begin errors++; $display("FAIL reserved_handshakes: got %0d want 2", seen.size()); end
    if (seen.size() == 2) begin
      checks++; if (seen[0] !== 32'hA || seen[1] !== 32'hB)
        begin errors++; $display("FAIL reserved_order: got %h,%h want a,b", seen[0], seen[1]); end
    end
    checks++; if (saw_reserved !== 0) begin errors++; $display("FAIL reserved_written: got %0d want 0", saw_reserved); end
    @(negedge clk);
    checks++; if (use_blocked !== 4'b0000) begin errors++; $display("FAIL reserved_ub: got %b want 0000", use_blocked); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reserved_idle: got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_reset_mid_write();
    rca_busy  = 4'b0000;
    cfg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_issue(1'b1, 3'd2, 2'(i), 8'(i), 32'(32'h700 + i));
      next_cycle();
    end
    drive_issue(1'b0, 3'd0, 2'd0, 8'h00, 32'h0);
    @(negedge clk);
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL rstw_pre_valid: got %b want 1", cfg_valid); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL rstw_same_cycle: got %b want 1", cfg_valid); end
    next_cycle();
    rst       = 1'b0;
    cfg_ready = 1'b1;
    @(negedge clk);
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rstw_valid: got %b want 0", cfg_valid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstw_idle: got %b want 1", idle); end
    checks++; if (use_blocked !== 4'b0000) begin errors++; $display("FAIL rstw_ub: got %b want 0000", use_blocked); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready: got %b want 1", issue_ready); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rstw_no_replay_%0d: got %b want 0", i, cfg_valid); end
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wait_quiesce();
    test_dest_reg_no_wait();
    test_full_and_order();
    test_reserved_skip();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
